// File: rtl/ft232h_cmd_engine_pkg.sv
// ============================================================================
// ft232h_pkg : opcodes, response codes and FSM states for ft232h_cmd_engine
// Rev 1.0
// ============================================================================
`default_nettype none

package ft232h_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_PING   = 8'h03;

  localparam logic [7:0] RSP_WACK  = 8'hA1;
  localparam logic [7:0] RSP_RDATA = 8'hA2;
  localparam logic [7:0] RSP_PONG  = 8'hA3;
  localparam logic [7:0] RSP_BADOP = 8'hEE;
  localparam logic [7:0] RSP_BUSTO = 8'hEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    BUS   = 3'd3,
    RWAIT = 3'd4,
    RESP  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ft232h_cmd_engine_resp_ser.sv
// ============================================================================
// ft232h_resp_ser : sends a header byte plus optional 4-byte payload (LSB first)
// Rev 1.0
// ============================================================================
`default_nettype none

module ft232h_resp_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  header,
  input  logic [31:0] payload,
  input  logic        long_resp,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] rest;
  logic [2:0]  remain;

  assign done = tx_valid & tx_ready & (remain == 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      rest     <= 32'h0;
      remain   <= 3'd0;
    end else if (load) begin
      tx_valid <= 1'b1;
      tx_data  <= header;
      rest     <= payload;
      remain   <= long_resp ? 3'd4 : 3'd0;
    end else if (tx_valid && tx_ready) begin
      if (remain == 3'd0) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data <= rest[7:0];
        rest    <= {8'h00, rest[31:8]};
        remain  <= remain - 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ft232h_cmd_engine.sv
// ============================================================================
// ft232h_cmd_engine : parses host command frames into 32-bit bus accesses
// Rev 1.0
// ============================================================================
`default_nettype none

module ft232h_cmd_engine
  import ft232h_pkg::*;
#(
  parameter int GAP_TIMEOUT = 1024,
  parameter int BUS_TIMEOUT = 256,
  parameter int TO_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam logic [TO_W-1:0] GAP_LIM = TO_W'(GAP_TIMEOUT - 1);
  localparam logic [TO_W-1:0] BUS_LIM = TO_W'(BUS_TIMEOUT - 1);

  state_t          state, next;
  logic            is_write;
  logic [1:0]      byte_idx;
  logic [TO_W-1:0] gap_cnt, bus_cnt;
  logic            accept, gap_to, bus_to, done;
  logic            ld, ld_long;
  logic [7:0]      ld_hdr;

  assign rx_ready  = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign accept    = rx_valid & rx_ready;
  assign busy      = (state != IDLE);
  assign bus_req   = (state == BUS);
  assign bus_we    = is_write;
  assign gap_to    = (gap_cnt >= GAP_LIM);
  assign bus_to    = (bus_cnt >= BUS_LIM);

  always_comb begin
    next    = state;
    ld      = 1'b0;
    ld_hdr  = RSP_BADOP;
    ld_long = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (rx_data == OP_WRITE || rx_data == OP_READ) begin
          next = ADDR;
        end else begin
          ld     = 1'b1;
          ld_hdr = (rx_data == OP_PING) ? RSP_PONG : RSP_BADOP;
          next   = RESP;
        end
      end
      ADDR: begin
        if (accept && byte_idx == 2'd3) next = is_write ? DATA : BUS;
        else if (!accept && gap_to)     next = IDLE;
      end
      DATA: begin
        if (accept && byte_idx == 2'd3) next = BUS;
        else if (!accept && gap_to)     next = IDLE;
      end
      BUS: begin
        // A grant on the timeout cycle still completes the access.
        if (bus_gnt) begin
          if (is_write) begin
            ld = 1'b1; ld_hdr = RSP_WACK; next = RESP;
          end else if (bus_rvalid) begin
            ld = 1'b1; ld_hdr = RSP_RDATA; ld_long = 1'b1; next = RESP;
          end else begin
            next = RWAIT;
          end
        end else if (bus_to) begin
          ld = 1'b1; ld_hdr = RSP_BUSTO; next = RESP;
        end
      end
      RWAIT: begin
        if (bus_rvalid) begin
          ld = 1'b1; ld_hdr = RSP_RDATA; ld_long = 1'b1; next = RESP;
        end else if (bus_to) begin
          ld = 1'b1; ld_hdr = RSP_BUSTO; next = RESP;
        end
      end
      RESP:    if (done) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      byte_idx  <= 2'd0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      gap_cnt   <= '0;
      bus_cnt   <= '0;
    end else begin
      state <= next;
      if (state == IDLE && accept) begin
        is_write <= (rx_data == OP_WRITE);
        byte_idx <= 2'd0;
      end
      if (state == ADDR || state == DATA) begin
        if (accept) begin
          gap_cnt  <= '0;
          byte_idx <= byte_idx + 2'd1;
          if (state == ADDR)
            bus_addr[8*byte_idx +: 8]  <= (byte_idx == 2'd0) ? (rx_data & 8'hFC) : rx_data;
          else
            bus_wdata[8*byte_idx +: 8] <= rx_data;
        end else begin
          gap_cnt <= gap_cnt + TO_W'(1);
        end
      end else begin
        gap_cnt <= '0;
      end
      // Only ADDR/DATA lead into BUS, so the counter is always zero on entry.
      if (state == BUS || state == RWAIT) bus_cnt <= bus_cnt + TO_W'(1);
      else                                bus_cnt <= '0;
    end
  end

  ft232h_resp_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .header    (ld_hdr),
    .payload   (bus_rdata),
    .long_resp (ld_long),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (done)
  );

endmodule

`default_nettype wire

// File: tb/tb_ft232h_cmd_engine.sv
// ============================================================================
// tb_ft232h_cmd_engine : directed self-checking bench for ft232h_cmd_engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ft232h_cmd_engine;

  localparam int GAP = 1024;
  localparam int BTO = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  logic [7:0] txq[$];

  ft232h_cmd_engine #(.GAP_TIMEOUT(GAP), .BUS_TIMEOUT(BTO), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
    if (!rst && bus_req) req_cnt <= req_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (k == 50) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b[]);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      @(posedge clk); k++;
    end
    #1;
    if (txq.size() < n) check("tx_wait", 32'(txq.size()), 32'(n));
  endtask

  task automatic check_tx(input string tag, input logic [7:0] exp[]);
    check({tag, "_len"}, 32'(txq.size()), 32'(exp.size()));
    foreach (exp[i]) if (i < txq.size()) check(tag, 32'(txq[i]), 32'(exp[i]));
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_bus_req",  32'(bus_req),  32'd0);
    check("rst_bus_we",   32'(bus_we),   32'd0);
    check("rst_bus_addr", bus_addr,      32'd0);
    check("rst_bus_wdata", bus_wdata,    32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // WRITE, grant after 3 request cycles
    txq.delete(); req_cnt = 0;
    send_frame('{8'h01, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    @(negedge clk);
    check("wr_req",   32'(bus_req), 32'd1);
    check("wr_we",    32'(bus_we),  32'd1);
    check("wr_addr",  bus_addr,     32'h80000010);
    check("wr_wdata", bus_wdata,    32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk); #1 bus_gnt = 1'b1;
    @(posedge clk); #1 bus_gnt = 1'b0;
    @(negedge clk);
    check("wr_tx_lat", 32'(tx_valid), 32'd1);
    check("wr_req_cycles", 32'(req_cnt), 32'd3);
    wait_tx(1, 50);
    check_tx("wr_resp", '{8'hA1});

    // READ, grant then rdata two cycles later
    txq.delete();
    send_frame('{8'h02, 8'h04, 8'h00, 8'h00, 8'h80});
    @(negedge clk);
    check("rd_req",  32'(bus_req), 32'd1);
    check("rd_we",   32'(bus_we),  32'd0);
    check("rd_addr", bus_addr,     32'h80000004);
    bus_gnt = 1'b1;
    @(posedge clk); #1 bus_gnt = 1'b0;
    @(negedge clk);
    check("rwait_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1 begin bus_rvalid = 1'b1; bus_rdata = 32'h12345678; end
    @(posedge clk); #1 bus_rvalid = 1'b0;
    @(negedge clk);
    check("rd_tx_lat", 32'(tx_valid), 32'd1);
    check("rd_tx_hdr", 32'(tx_data),  32'hA2);
    wait_tx(5, 50);
    check_tx("rd_resp", '{8'hA2, 8'h78, 8'h56, 8'h34, 8'h12});

    // PING with tx back-pressure
    txq.delete();
    tx_ready = 1'b0;
    send_byte(8'h03);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ping_valid", 32'(tx_valid), 32'd1);
      check("ping_data",  32'(tx_data),  32'hA3);
      check("ping_rxrdy", 32'(rx_ready), 32'd0);
    end
    tx_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ping_idle",  32'(busy),     32'd0);
    check("ping_rxrdy_after", 32'(rx_ready), 32'd1);
    check_tx("ping_resp", '{8'hA3});

    // Unknown opcode, then a read with simultaneous grant and rdata
    txq.delete();
    send_byte(8'h5A);
    wait_tx(1, 50);
    check_tx("badop_resp", '{8'hEE});
    txq.delete();
    send_frame('{8'h02, 8'h0B, 8'h00, 8'h00, 8'h00});
    @(negedge clk);
    check("rd2_addr_align", bus_addr, 32'h00000008);
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1 begin bus_gnt = 1'b0; bus_rvalid = 1'b0; end
    @(negedge clk);
    check("rd2_tx_lat", 32'(tx_valid), 32'd1);
    wait_tx(5, 50);
    check_tx("rd2_resp", '{8'hA2, 8'h0D, 8'hF0, 8'hFE, 8'hCA});

    // Bus timeout, late rvalid ignored
    txq.delete(); req_cnt = 0;
    send_frame('{8'h02, 8'h00, 8'h01, 8'h00, 8'h00});
    wait_tx(1, BTO + 50);
    check("bto_req_cycles", 32'(req_cnt), 32'(BTO));
    check_tx("bto_resp", '{8'hEF});
    bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
    @(posedge clk); #1 bus_rvalid = 1'b0;
    repeat (10) @(posedge clk);
    check("bto_late_rvalid", 32'(txq.size()), 32'd1);

    // Gap timeout on a partial frame
    txq.delete();
    send_frame('{8'h01, 8'h00});
    repeat (GAP - 10) @(posedge clk);
    @(negedge clk);
    check("gap_still_busy", 32'(busy), 32'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("gap_idle",  32'(busy),       32'd0);
    check("gap_rxrdy", 32'(rx_ready),   32'd1);
    check("gap_no_tx", 32'(txq.size()), 32'd0);

    // Reset during a write bus cycle
    send_frame('{8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    @(negedge clk);
    check("rstbus_req_before", 32'(bus_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rstbus_req",  32'(bus_req), 32'd0);
    check("rstbus_busy", 32'(busy),    32'd0);
    check("rstbus_addr", bus_addr,     32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rstbus_no_tx", 32'(txq.size()), 32'd0);
    check("rstbus_txv",   32'(tx_valid),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ft232h_cmd_engine.md
Name: ft232h_cmd_engine

Overview:
- Sits directly downstream of the FT232H sync-FIFO bridge (ip_ft232h) on the FPGA side.
- Consumes the received host byte stream and parses fixed-format command frames.
- Issues single 32-bit bus transactions into the SoC.
- Returns response bytes to the bridge's transmit path, making the FT232H link a host debug/memory-access port.

Parameters:
- GAP_TIMEOUT, 1024, idle cycles allowed between bytes of one frame before the partial frame is discarded.
- BUS_TIMEOUT, 256, cycles allowed from bus_req assertion to completion before an error response is sent.
- TO_W, 16, width of both timeout counters; must satisfy 2^TO_W > max(GAP_TIMEOUT, BUS_TIMEOUT).

Ports:
- clk  in  1  system clock, same domain as the bridge's FPGA-side FIFO interface
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  byte received from host
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  engine accepts rx byte this cycle
- tx_data  out  8  response byte to host
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  bridge accepts tx byte this cycle
- bus_req  out  1  bus request, held until bus_gnt or timeout
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  32  word address (bits [1:0] forced to 0)
- bus_wdata  out  32  write data
- bus_gnt  in  1  request accepted (write complete / read issued)
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): state = IDLE; rx_ready=1, tx_valid=0, tx_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0; all counters 0.
  - Reset mid-frame or mid-bus-cycle drops all progress; no response is sent.
- Byte handshakes: a transfer occurs on the clk edge where valid & ready. rx_ready is high only in IDLE, ADDR and DATA.
- Frame formats (multi-byte fields little-endian):
  - 0x01 WRITE: opcode, addr[4], data[4]
  - 0x02 READ: opcode, addr[4]
  - 0x03 PING: opcode only
- Response formats:
  - WRITE: 0xA1
  - READ: 0xA2 then rdata[4], LSB first
  - PING: 0xA3
  - Unknown opcode: 0xEE
  - Bus timeout: 0xEF
- States:
  - IDLE: on accepted byte: opcode 0x01/0x02 -> ADDR (latch opcode, byte_idx=0); 0x03 -> RESP (load 0xA3); any other value -> RESP (load 0xEE). No other bytes are consumed.
  - ADDR: on each accepted byte, shift it into addr[8*byte_idx +: 8] and increment byte_idx. After the 4th byte: WRITE -> DATA (byte_idx=0); READ -> BUS.
  - DATA: collect 4 bytes into wdata the same way, then -> BUS.
  - BUS: bus_req=1 and bus_we per opcode. Write plus bus_gnt -> RESP(0xA1). Read plus bus_gnt -> RWAIT.
  - RWAIT: bus_req=0. bus_rvalid -> latch rdata -> RESP(0xA2 + 4 data bytes).
  - In BUS or RWAIT, if the bus counter reaches BUS_TIMEOUT -> drop bus_req, RESP(0xEF). A late bus_rvalid arriving after this is ignored.
  - RESP: present response bytes in order. tx_valid stays high and tx_data stays stable until tx_ready. After the last byte is accepted -> IDLE, in the same cycle.
- Gap timeout:
  - Counter runs in ADDR/DATA, clears on every accepted byte.
  - Reaching GAP_TIMEOUT -> IDLE silently, with no response.
- Bus counter: cleared on entry to BUS and keeps counting through RWAIT.
- Latency:
  - Final frame byte accepted -> bus_req high on the next cycle.
  - bus_gnt (write) or bus_rvalid (read) -> tx_valid high on the next cycle.
  - PING byte accepted -> tx_valid high on the next cycle.
- Simultaneous bus_gnt and bus_rvalid in BUS for a read: treat as read complete and go straight to RESP with that rdata.
- bus_gnt in the same cycle the timeout fires: the grant wins.
- Back-pressure: a new frame is not accepted while RESP is pending, since rx_ready=0.

Decomposition:
- Package ft232h_pkg holds:
  - opcode constants OP_WRITE=0x01, OP_READ=0x02, OP_PING=0x03
  - response constants RSP_WACK=0xA1, RSP_RDATA=0xA2, RSP_PONG=0xA3, RSP_BADOP=0xEE, RSP_BUSTO=0xEF
  - state enum: IDLE, ADDR, DATA, BUS, RWAIT, RESP
- One sub-module, ft232h_resp_ser, a response serializer:
  - Loads {header, 32-bit payload, length 1 or 5}.
  - Drives tx_valid/tx_data and pulses done when the last byte is accepted.

Test Plan:
- Bytes 01 10 00 00 80 EF BE AD DE, bus_gnt after 3 cycles -> one bus_req with we=1, addr=0x80000010, wdata=0xDEADBEEF; tx emits A1.
- Bytes 02 04 00 00 80, bus_gnt then bus_rvalid with rdata=0x12345678 two cycles later -> we=0, addr=0x80000004; tx emits A2 78 56 34 12.
- Byte 03 with tx_ready low for 5 cycles -> tx_valid=1 and tx_data=A3 held stable throughout, rx_ready=0; after acceptance, state IDLE and rx_ready=1.
- Byte 5A -> tx emits EE. A following READ frame then completes normally.
- READ frame with bus_gnt never asserted -> bus_req drops after BUS_TIMEOUT cycles; tx emits EF; a later bus_rvalid produces no extra tx bytes.
- Bytes 01 00 followed by GAP_TIMEOUT idle cycles -> engine returns to IDLE with no tx output. Then assert rst mid-write in BUS -> bus_req=0 immediately and no response.
